// File: rtl/stopwatch_display_if.sv
// rtl/stopwatch_display_if.sv - count/mode inputs and seven-segment outputs of the stopwatch display
interface stopwatch_display_if #(
    parameter int WIDTH = 14
);
    logic [WIDTH-1:0] number;
    logic [1:0]       pausa;
    logic [0:6]       dis0;
    logic [0:6]       dis1;
    logic [0:6]       dis2;
    logic [0:6]       dis3;
    logic             busy;
    logic             overflow;

    modport master (
        output number, pausa,
        input  dis0, dis1, dis2, dis3, busy, overflow
    );

    modport slave (
        input  number, pausa,
        output dis0, dis1, dis2, dis3, busy, overflow
    );
endinterface

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - double-dabble BCD conversion and seven-segment drive with freeze/blank/blink
module stopwatch_display #(
    parameter int WIDTH      = 14,
    parameter int BLINK_HALF = 2500000
) (
    input  logic                clk,
    input  logic                rst_n,
    stopwatch_display_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    localparam int SW = WIDTH + 16;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(9999);
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_DASH  = 7'b1111110;

    state_t           state, state_nx;
    logic [SW-1:0]    sr, sr_adj;
    logic [CW-1:0]    shift_cnt;
    logic [WIDTH-1:0] number, cap, last;
    logic             last_valid;
    logic             start, cap_ovf;
    logic [15:0]      dig, shown;
    logic             ovf, shown_ovf;
    logic [1:0]       mode;
    logic [BW-1:0]    blink_cnt;
    logic             phase;
    logic             blank;

    assign number  = bus.number;
    assign start   = !last_valid || (number != last);
    assign cap_ovf = (cap > MAX_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (shift_cnt == CW'(WIDTH - 1)) state_nx = LATCH;
            LATCH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble before each shift
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 4; i++) begin
            if (sr[WIDTH + 4*i +: 4] >= 4'd5)
                sr_adj[WIDTH + 4*i +: 4] = sr[WIDTH + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr         <= '0;
            shift_cnt  <= '0;
            cap        <= '0;
            last       <= '0;
            last_valid <= 1'b0;
            dig        <= '0;
            ovf        <= 1'b0;
            shown      <= '0;
            shown_ovf  <= 1'b0;
            mode       <= 2'd0;
        end else begin
            mode <= bus.pausa;
            case (state)
                IDLE: begin
                    sr        <= {16'd0, number};
                    cap       <= number;
                    shift_cnt <= '0;
                end
                SHIFT: begin
                    sr        <= {sr_adj[SW-2:0], 1'b0};
                    shift_cnt <= shift_cnt + 1'b1;
                end
                LATCH: begin
                    dig        <= sr[WIDTH +: 16];
                    ovf        <= cap_ovf;
                    last       <= cap;
                    last_valid <= 1'b1;
                end
                default: ;
            endcase
            // Modes 0 and 2 track; at LATCH bypass the digit registers so latency stays 15 cycles
            if (!bus.pausa[0]) begin
                if (state == LATCH) begin
                    shown     <= sr[WIDTH +: 16];
                    shown_ovf <= cap_ovf;
                end else begin
                    shown     <= dig;
                    shown_ovf <= ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (bus.pausa != 2'd3 || mode != 2'd3) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    function automatic logic [0:6] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    assign blank = (mode == 2'd2) || (mode == 2'd3 && !phase);

    assign bus.dis0     = blank ? SEG_BLANK : shown_ovf ? SEG_DASH : seg7(shown[3:0]);
    assign bus.dis1     = blank ? SEG_BLANK : shown_ovf ? SEG_DASH : seg7(shown[7:4]);
    assign bus.dis2     = blank ? SEG_BLANK : shown_ovf ? SEG_DASH : seg7(shown[11:8]);
    assign bus.dis3     = blank ? SEG_BLANK : shown_ovf ? SEG_DASH : seg7(shown[15:12]);
    assign bus.busy     = (state != IDLE);
    assign bus.overflow = ovf;
endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - scoreboard bench for stopwatch_display
module tb_stopwatch_display;
    logic clk = 1'b0;
    logic rst_n;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          cyc;
        logic [27:0] dis;
        bit          cd;
        logic        busy;
        bit          cb;
        logic        ovf;
        bit          co;
        string       name;
    } exp_t;

    exp_t sb[$];

    stopwatch_display_if #(.WIDTH(14)) bus();

    stopwatch_display #(.WIDTH(14), .BLINK_HALF(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0:  seg = 7'b0000001;
            1:  seg = 7'b1001111;
            2:  seg = 7'b0010010;
            3:  seg = 7'b0000110;
            4:  seg = 7'b1001100;
            5:  seg = 7'b0100100;
            6:  seg = 7'b0100000;
            7:  seg = 7'b0001111;
            8:  seg = 7'b0000000;
            9:  seg = 7'b0000100;
            10: seg = 7'b1111110;
            default: seg = 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] disp(input int d3, input int d2, input int d1, input int d0);
        disp = {seg(d3), seg(d2), seg(d1), seg(d0)};
    endfunction

    task automatic expect_at(input int dc, input logic [27:0] d, input bit cd,
                             input logic b, input bit cb, input logic o, input bit co,
                             input string nm);
        exp_t e;
        e.cyc = dc; e.dis = d; e.cd = cd; e.busy = b; e.cb = cb; e.ovf = o; e.co = co; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops every expectation due at this cycle and compares away from the active edge
    always @(negedge clk) begin
        logic [27:0] act;
        exp_t        e;
        act = {bus.dis3, bus.dis2, bus.dis1, bus.dis0};
        while (sb.size() > 0 && sb[0].cyc <= cycle) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < cycle) begin
                errors++;
                $display("FAIL %s missed: due cycle %0d, seen at %0d", e.name, e.cyc, cycle);
            end else if ((e.cd && act != e.dis) || (e.cb && bus.busy !== e.busy) ||
                         (e.co && bus.overflow !== e.ovf)) begin
                errors++;
                $display("FAIL %s cyc=%0d got dis=%b busy=%b ovf=%b required dis=%b busy=%b ovf=%b",
                         e.name, cycle, act, bus.busy, bus.overflow, e.dis, e.busy, e.ovf);
            end
        end
    end

    task automatic convert(input int v, input logic [27:0] d, input logic o, input string nm);
        int k;
        k = cycle;
        bus.number = 14'(v);
        expect_at(k + 1,  '0, 0, 1'b1, 1, 1'b0, 0, {nm, "_busy"});
        expect_at(k + 15, '0, 0, 1'b1, 1, 1'b0, 0, {nm, "_busy_last"});
        expect_at(k + 16, d, 1, 1'b0, 1, o, 1, nm);
        step(17);
    endtask

    initial begin
        int k;
        int c;
        logic [27:0] b7;
        rst_n      = 1'b0;
        bus.number = '0;
        bus.pausa  = 2'd0;
        step(3);

        k = cycle;
        expect_at(k,      disp(0,0,0,0), 1, 1'b0, 1, 1'b0, 1, "reset");
        rst_n = 1'b1;
        expect_at(k + 1,  '0, 0, 1'b1, 1, 1'b0, 0, "first_busy");
        expect_at(k + 5,  disp(0,0,0,0), 1, 1'b1, 1, 1'b0, 0, "first_mid");
        expect_at(k + 16, disp(0,0,0,0), 1, 1'b0, 1, 1'b0, 1, "first_done");
        expect_at(k + 20, '0, 0, 1'b0, 1, 1'b0, 0, "idle_same");
        step(21);

        convert(1234,  disp(1,2,3,4), 1'b0, "v1234");
        convert(9999,  disp(9,9,9,9), 1'b0, "v9999");
        convert(0,     disp(0,0,0,0), 1'b0, "v0");
        convert(10000, disp(10,10,10,10), 1'b1, "v10000");
        convert(5,     disp(0,0,0,5), 1'b0, "v5");
        convert(42,    disp(0,0,4,2), 1'b0, "v42");

        k = cycle;
        bus.pausa  = 2'd1;
        bus.number = 14'd43;
        expect_at(k + 1,  disp(0,0,4,2), 1, 1'b1, 1, 1'b0, 0, "freeze_busy");
        expect_at(k + 16, disp(0,0,4,2), 1, 1'b0, 1, 1'b0, 1, "freeze_hold");
        step(17);
        k = cycle;
        bus.pausa = 2'd0;
        expect_at(k,     disp(0,0,4,2), 1, 1'b0, 0, 1'b0, 0, "unfreeze_before");
        expect_at(k + 1, disp(0,0,4,3), 1, 1'b0, 0, 1'b0, 0, "unfreeze_after");
        step(2);

        convert(7, disp(0,0,0,7), 1'b0, "v7");
        k = cycle;
        bus.pausa = 2'd3;
        b7 = disp(0,0,0,7);
        for (int i = 1; i <= 12; i++) begin
            if (((i - 1) / 4) % 2 == 0)
                expect_at(k + i, b7, 1, 1'b0, 0, 1'b0, 0, "blink_on");
            else
                expect_at(k + i, disp(11,11,11,11), 1, 1'b0, 0, 1'b0, 0, "blink_off");
        end
        step(12);

        k = cycle;
        bus.pausa  = 2'd2;
        bus.number = 14'd8;
        expect_at(k + 1,  disp(11,11,11,11), 1, 1'b1, 1, 1'b0, 0, "blank_busy");
        expect_at(k + 16, disp(11,11,11,11), 1, 1'b0, 1, 1'b0, 1, "blank_done");
        step(17);
        k = cycle;
        bus.pausa = 2'd0;
        expect_at(k + 1, disp(0,0,0,8), 1, 1'b0, 0, 1'b0, 0, "live_after_blank");
        step(2);

        c = cycle;
        bus.number = 14'd777;
        expect_at(c + 5, disp(0,0,0,8), 1, 1'b1, 1, 1'b0, 0, "pre_abort");
        step(6);
        rst_n = 1'b0;
        expect_at(c + 6, disp(0,0,0,0), 1, 1'b0, 1, 1'b0, 1, "abort_reset");
        step(2);
        rst_n = 1'b1;
        expect_at(c + 9,  '0, 0, 1'b1, 1, 1'b0, 0, "v777_busy");
        expect_at(c + 23, disp(0,0,0,0), 1, 1'b1, 1, 1'b0, 0, "v777_pending");
        expect_at(c + 24, disp(0,7,7,7), 1, 1'b0, 1, 1'b0, 1, "v777_done");
        step(18);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Display back end for the stopwatch counter. Consumes the 14-bit tenths-of-second count and the 2-bit pause/display mode that the counter produces.
- Converts the count to four BCD digits with a sequential shift-add-3 (double-dabble) engine, then drives four active-low seven-segment displays.
- Supports freeze, blank and blink modes, and shows dashes on out-of-range input.

Parameters:
- WIDTH, 14, width of the binary count input.
- BLINK_HALF, 2500000, clk cycles per on-phase and per off-phase in blink mode (must be ≥1).

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- number  input  WIDTH  binary count; valid range 0..9999.
- pausa  input  2  display mode: 0 live, 1 frozen, 2 blank, 3 frozen+blink.
- dis0  output  [0:6]  units digit, segments a..g, active-low.
- dis1  output  [0:6]  tens digit.
- dis2  output  [0:6]  hundreds digit.
- dis3  output  [0:6]  thousands digit.
- busy  output  1  high while a conversion is in progress (SHIFT or LATCH).
- overflow  output  1  high when the last converted value was >9999.

Behaviour:
- Reset (async assert, sync-safe release):
  - state=IDLE; digit registers=0; shown registers=0; dis0..dis3=7'b0000001 ("0").
  - busy=0, overflow=0; blink counter=0, phase=on.
  - "last converted" flag invalid, so a conversion always starts on the first IDLE cycle after reset.
- Conversion FSM (states IDLE, SHIFT, LATCH):
  - IDLE, edge C: capture number into the shift register. If it differs from last converted, or last converted is invalid, go to SHIFT with busy=1. Otherwise stay in IDLE.
  - SHIFT: exactly WIDTH edges (C+1..C+14). Each edge first adds 3 to every BCD nibble ≥5, then shifts left by 1.
  - LATCH, edge C+15: write the BCD result to the digit registers and record last converted. Set overflow=(captured>9999). Return to IDLE; busy=0.
  - Result: a new value is visible on dis* after edge C+15, i.e. 15 cycles of latency from capture.
- number changes while busy are ignored. The latest value is captured at the next IDLE edge, and only the final stable value is guaranteed to be displayed.
- Overflow: a captured value >9999 displays "----" (7'b1111110 on all four digits) and sets overflow=1. The next in-range conversion clears overflow.
- Segment encoding [0:6]=a..g, 0=lit:
  - 0 → 0000001, 1 → 1001111, 2 → 0010010, 3 → 0000110, 4 → 1001100
  - 5 → 0100100, 6 → 0100000, 7 → 0001111, 8 → 0000000, 9 → 0000100
  - blank → 1111111
  - Leading zeros are displayed.
- The shown registers drive the outputs, and the conversion always runs.
- Modes:
  - pausa=0: shown registers load from the digit registers at every LATCH.
  - pausa=1: shown registers hold; LATCH updates only the digit registers. On a return to 0, the shown registers reload from the digit registers on the next edge.
  - pausa=2: all outputs 1111111; shown registers track as in mode 0.
  - pausa=3: shown registers hold as in mode 1. Outputs alternate: BLINK_HALF cycles showing the held value, then BLINK_HALF cycles blank.
- Blink counter:
  - Resets to 0 with phase=on on every edge where pausa≠3, so entering mode 3 always starts with a full on-phase.
  - Wraps from BLINK_HALF-1 to 0 and toggles phase.
- Mode changes take effect on the output after the edge that samples the new pausa; they do not disturb the FSM.
- Reset mid-conversion aborts the conversion immediately and restores reset values. No partial result is ever latched.
- Outputs are registered, glitch-free combinational decode of registered state only.

Test Plan:
- Reset release with number=0, pausa=0 → dis3..dis0 = "0000" throughout. busy pulses high for edges C+1..C+15 after the first IDLE edge, then stays low while number is unchanged.
- number=1234 held → after C+15: dis3=1001111, dis2=0010010, dis1=0000110, dis0=1001100; overflow=0.
- number=9999 then 0 (rollover) → "9999" then "0000", each 15 cycles after its capture. number=10000 → all digits 1111110, overflow=1; then number=5 → "0005", overflow=0.
- pausa=1 at display "0042", then number=43 → busy pulses but display stays "0042". pausa=0 → "0043" on the next edge.
- BLINK_HALF=4, pausa=3 holding "0007" → 4 cycles "0007", 4 cycles all 1111111, repeating. pausa=2 → all blank. pausa=0 → live.
- rst_n asserted 5 cycles into converting 777 → outputs immediately "0000", busy=0. After release, 777 converts and displays after C+15.
